cam_reg_sequencer: RTL and testbench
====================================

Name: cam_reg_sequencer

Overview:
- Parametrised camera register-initialisation sequencer.
- Walks a register table held in an external synchronous ROM. Issues one I2C register write per entry through a request/done handshake to a separate byte-level I2C master.
- Supports timed-delay entries, NACK retry, re-triggerable runs and done/error status.
- Sits between the camera power-up/reset control and the I2C master. Gates the video capture path via cfg_done.

Parameters:
- NUM_ENTRIES, 357: number of table entries executed per run (indices 0..NUM_ENTRIES-1).
- IDX_W, 9: width of the table index; must satisfy 2^IDX_W >= NUM_ENTRIES.
- REG_ADDR_W, 16: register address width, either 8 or 16; passed to the master via i2c_addr16.
- DEV_ADDR, 7'h3C: 7-bit device address (8-bit write address 0x78).
- CLK_FREQ_HZ, 25000000: clk frequency, used to derive the 1 ms tick.
- MAX_RETRY, 3: additional attempts after a NACK before error (0 = no retry).

Ports:
- clk  in  1  system clock
- camera_rst  in  1  reset
- cfg_start  in  1  one-cycle pulse; starts or restarts a run
- rom_addr  out  IDX_W  table index
- rom_data  in  REG_ADDR_W+8  entry {reg_addr, data}; valid exactly 1 cycle after rom_addr changes
- i2c_req  out  1  transaction request, held until i2c_done
- i2c_rw  out  1  0=write, 1=read
- i2c_dev_addr  out  7  equals DEV_ADDR
- i2c_addr16  out  1  1 when REG_ADDR_W==16
- i2c_reg_addr  out  REG_ADDR_W  register address
- i2c_wdata  out  8  write data
- i2c_done  in  1  one-cycle pulse ending a transaction
- i2c_nack  in  1  valid with i2c_done; 1 = transaction failed
- i2c_rdata  in  8  read data, valid with i2c_done
- cfg_busy  out  1  run in progress
- cfg_done  out  1  sticky; all entries completed
- cfg_error  out  1  sticky; run aborted
- err_index  out  IDX_W  entry index that caused the abort

Behaviour:
- Reset is asynchronous and active-high on camera_rst; single clock domain clk.
- All outputs reset to 0, except i2c_dev_addr and i2c_addr16, which are constants. State resets to IDLE; retry and delay counters reset to 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_I2C, DELAY, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR: cfg_start sets index 0, clears cfg_done, cfg_error and err_index, and moves to FETCH. cfg_start is ignored while cfg_busy=1.
- cfg_busy=1 in every state except IDLE, DONE and ERROR.
- FETCH: drive rom_addr=index; wait 1 cycle.
- DECODE: register rom_data.
  - reg_addr all-ones marks a delay entry: load data*1 ms into the delay counter, then go to DELAY. data=0 goes straight to NEXT.
  - Otherwise go to ISSUE.
- ISSUE: assert i2c_req with rw=0 and stable addr/data; go to WAIT_I2C.
- WAIT_I2C: hold i2c_req and payload until i2c_done, then drop i2c_req on the following cycle.
  - nack=0: retry counter cleared, go to NEXT.
  - nack=1 and retries < MAX_RETRY: increment retries, back to ISSUE.
  - Otherwise set cfg_error=1, err_index=index, go to ERROR.
- DELAY: 1 ms tick from a free-running prescaler reloaded at DELAY entry (CLK_FREQ_HZ/1000 cycles). Exit to NEXT when the counter reaches 0.
- NEXT: if index==NUM_ENTRIES-1, set cfg_done=1 and go to DONE. Otherwise increment index and go to FETCH. The index never wraps.
- i2c_done outside WAIT_I2C is ignored.
- Reset mid-transaction: i2c_req drops asynchronously; the master is expected to be reset by the same camera_rst.
- Latency per write entry: 3 cycles plus master time to i2c_done, plus 1 cycle in NEXT.

Optional Feature:
- Macro CAM_REG_READBACK_VERIFY_EN.
- Defined:
  - A successful write goes to a VERIFY state, which issues a read (rw=1) of the same reg_addr.
  - On i2c_done with nack=0 and rdata==written data, go to NEXT.
  - A read NACK or data mismatch counts as one failure on the same retry budget; retry restarts from the write.
- Undefined: VERIFY state and read path are absent; i2c_rw is tied to 0.

Test Plan:
- NUM_ENTRIES=4, table {3103_11, 3008_82, 3017_FF, 3018_FF}; master acks after 10 cycles; pulse cfg_start -> exactly 4 write requests with those addr/data in order, then cfg_done=1, cfg_busy=0, cfg_error=0.
- Entry 1 = {FFFF_05} at CLK_FREQ_HZ=1000000 -> no i2c_req for 5000±2 cycles between entry 0 done and entry 2 request; {FFFF_00} gives no delay.
- NACK on entry 2 twice, then ack, MAX_RETRY=3 -> 3 requests for entry 2, run completes with cfg_done=1.
- NACK on entry 2 always, MAX_RETRY=3 -> 4 requests, then cfg_error=1, err_index=2, cfg_done=0, no further requests. cfg_start then restarts from index 0.
- Assert camera_rst while WAIT_I2C is on entry 1 -> all outputs 0 immediately (asynchronous). A new cfg_start after release begins at index 0.
- With CAM_REG_READBACK_VERIFY_EN: read returns 0x80 for written 0x82 -> retried write; after MAX_RETRY mismatches, cfg_error=1 with err_index of that entry.

Source files
------------

// File: rtl/cam_reg_sequencer.sv
// Camera register-initialisation sequencer: walks a ROM table and issues one I2C write per entry.
// Optional read-back verification of every write is enabled by defining CAM_REG_READBACK_VERIFY_EN.
module cam_reg_sequencer #(
    parameter int unsigned NUM_ENTRIES = 357,
    parameter int unsigned IDX_W       = 9,
    parameter int unsigned REG_ADDR_W  = 16,
    parameter logic [6:0]  DEV_ADDR    = 7'h3C,
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    camera_rst,
    input  logic                    cfg_start,
    output logic [IDX_W-1:0]        rom_addr,
    input  logic [REG_ADDR_W+7:0]   rom_data,
    output logic                    i2c_req,
    output logic                    i2c_rw,
    output logic [6:0]              i2c_dev_addr,
    output logic                    i2c_addr16,
    output logic [REG_ADDR_W-1:0]   i2c_reg_addr,
    output logic [7:0]              i2c_wdata,
    input  logic                    i2c_done,
    input  logic                    i2c_nack,
    input  logic [7:0]              i2c_rdata,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error,
    output logic [IDX_W-1:0]        err_index
);

    localparam int unsigned TICK    = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int unsigned PRESC_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned DATA_W  = 8;
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [REG_ADDR_W-1:0] DELAY_MARK = '1;

`ifdef CAM_REG_READBACK_VERIFY_EN
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_I2C, S_DELAY, S_NEXT, S_DONE, S_ERROR, S_VERIFY
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_I2C, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    req_q, req_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [DATA_W-1:0]       ms_q, ms_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;
    logic                    xfer_ok;

    // A transfer succeeds on ACK; a read-back must also return the written byte.
`ifdef CAM_REG_READBACK_VERIFY_EN
    logic rw_q, rw_d;
    assign xfer_ok = !i2c_nack && (!rw_q || (i2c_rdata == wdata_q));
    assign i2c_rw  = rw_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^i2c_rdata;
    assign xfer_ok      = !i2c_nack;
    assign i2c_rw       = 1'b0;
`endif

    assign rom_addr     = idx_q;
    assign i2c_req      = req_q;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_addr16   = (REG_ADDR_W == 16);
    assign i2c_reg_addr = reg_addr_q;
    assign i2c_wdata    = wdata_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_error    = error_q;
    assign err_index    = err_idx_q;

    always_ff @(posedge clk or posedge camera_rst) begin
        if (camera_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            retry_q    <= '0;
            ms_q       <= '0;
            presc_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
`ifdef CAM_REG_READBACK_VERIFY_EN
            rw_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            retry_q    <= retry_d;
            ms_q       <= ms_d;
            presc_q    <= presc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
`ifdef CAM_REG_READBACK_VERIFY_EN
            rw_q       <= rw_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        req_d      = req_q;
        retry_d    = retry_q;
        ms_d       = ms_q;
        presc_d    = presc_q;
        done_d     = done_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
`ifdef CAM_REG_READBACK_VERIFY_EN
        rw_d       = rw_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (cfg_start) begin
                    idx_d     = '0;
                    retry_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                reg_addr_d = rom_data[REG_ADDR_W+7:8];
                wdata_d    = rom_data[7:0];
                if (rom_data[REG_ADDR_W+7:8] == DELAY_MARK) begin
                    if (rom_data[7:0] == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        ms_d    = rom_data[7:0];
                        presc_d = PRESC_W'(TICK - 1);
                        state_d = S_DELAY;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_d   = 1'b1;
`ifdef CAM_REG_READBACK_VERIFY_EN
                rw_d    = 1'b0;
`endif
                state_d = S_WAIT_I2C;
            end
`ifdef CAM_REG_READBACK_VERIFY_EN
            S_VERIFY: begin
                req_d   = 1'b1;
                rw_d    = 1'b1;
                state_d = S_WAIT_I2C;
            end
`endif
            S_WAIT_I2C: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    if (xfer_ok) begin
`ifdef CAM_REG_READBACK_VERIFY_EN
                        if (rw_q) begin
                            retry_d = '0;
                            state_d = S_NEXT;
                        end else begin
                            state_d = S_VERIFY;
                        end
`else
                        retry_d = '0;
                        state_d = S_NEXT;
`endif
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_ISSUE;
                    end else begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_ERROR;
                    end
                end
            end
            // Prescaler produces one tick per millisecond; ms_q counts remaining ticks.
            S_DELAY: begin
                if (presc_q == '0) begin
                    presc_d = PRESC_W'(TICK - 1);
                    ms_d    = ms_q - DATA_W'(1);
                    if (ms_q == DATA_W'(1)) begin
                        state_d = S_NEXT;
                    end
                end else begin
                    presc_d = presc_q - PRESC_W'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    end

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Self-checking bench for cam_reg_sequencer: ROM and I2C master models plus a run-level reference model.
module tb_cam_reg_sequencer;

    localparam int unsigned NE     = 4;
    localparam int unsigned IW     = 2;
    localparam int unsigned RAW    = 16;
    localparam int unsigned MR     = 3;
    localparam int unsigned CLK_HZ = 1000000;

    logic            clk = 1'b0;
    logic            camera_rst;
    logic            cfg_start;
    logic [IW-1:0]   rom_addr;
    logic [RAW+7:0]  rom_data;
    logic            i2c_req, i2c_rw, i2c_addr16;
    logic [6:0]      i2c_dev_addr;
    logic [RAW-1:0]  i2c_reg_addr;
    logic [7:0]      i2c_wdata;
    logic            i2c_done  = 1'b0;
    logic            i2c_nack  = 1'b0;
    logic [7:0]      i2c_rdata = 8'h00;
    logic            cfg_busy, cfg_done, cfg_error;
    logic [IW-1:0]   err_index;

    int total = 0;
    int bad   = 0;

    cam_reg_sequencer #(
        .NUM_ENTRIES(NE), .IDX_W(IW), .REG_ADDR_W(RAW), .DEV_ADDR(7'h3C),
        .CLK_FREQ_HZ(CLK_HZ), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .camera_rst(camera_rst), .cfg_start(cfg_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_dev_addr(i2c_dev_addr), .i2c_addr16(i2c_addr16),
        .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: one cycle read latency
    logic [23:0] tbl [NE];
    always @(posedge clk) rom_data <= tbl[rom_addr];

    // I2C master model policy (written by stimulus only)
    int          m_lat;
    logic [15:0] nack_addr, corr_addr;
    int          nack_lim, corr_lim;

    // I2C master model state and logs (written by the master only)
    bit          m_active = 1'b0;
    int          m_cnt = 0;
    logic        m_rw;
    logic [15:0] m_addr;
    logic [7:0]  m_data, last_wdata = 8'h00;
    int          nack_given = 0, corr_given = 0;
    bit          nk;
    logic [24:0] req_log [$];
    int          req_cyc [$];
    int          done_cyc [$];

    always @(negedge clk) begin
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (cfg_start) begin
            nack_given = 0;
            corr_given = 0;
            req_log.delete();
            req_cyc.delete();
            done_cyc.delete();
        end
        if (camera_rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_cnt == 0) begin
                m_active = 1'b0;
                i2c_done = 1'b1;
                done_cyc.push_back(cyc);
                if (!m_rw) begin
                    nk = (m_addr == nack_addr) && (nack_given < nack_lim);
                    if (nk) nack_given++;
                    else last_wdata = m_data;
                    i2c_nack = nk;
                end else begin
                    nk = (m_addr == corr_addr) && (corr_given < corr_lim);
                    if (nk) corr_given++;
                    i2c_rdata = nk ? (last_wdata ^ 8'h02) : last_wdata;
                end
            end else begin
                m_cnt--;
            end
        end else if (i2c_req) begin
            m_active = 1'b1;
            m_cnt    = (m_lat > 0) ? m_lat - 1 : int'($urandom_range(1, 11));
            m_rw     = i2c_rw;
            m_addr   = i2c_reg_addr;
            m_data   = i2c_wdata;
            req_log.push_back({i2c_rw, i2c_reg_addr, i2c_wdata});
            req_cyc.push_back(cyc);
        end
    end

    // Reference model: expected transaction list and final status of one run
    logic [24:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_idx;

    task automatic compute_expected();
        int n_left, c_left, tries;
        logic [15:0] a;
        logic [7:0]  d;
        bit fail;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_idx  = 0;
        n_left   = nack_lim;
        c_left   = corr_lim;
        for (int e = 0; e < int'(NE); e++) begin
            a = tbl[e][23:8];
            d = tbl[e][7:0];
            if (a == 16'hFFFF) continue;
            tries = 0;
            forever begin
                exp_q.push_back({1'b0, a, d});
                fail = (a == nack_addr) && (n_left > 0);
                if (fail) n_left--;
`ifdef CAM_REG_READBACK_VERIFY_EN
                if (!fail) begin
                    exp_q.push_back({1'b1, a, d});
                    fail = (a == corr_addr) && (c_left > 0);
                    if (fail) c_left--;
                end
`endif
                if (!fail) break;
                if (tries == int'(MR)) begin
                    exp_err = 1'b1;
                    exp_idx = e;
                    return;
                end
                tries++;
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
    endtask

    task automatic run_check(input string tag, input int budget);
        int n;
        compute_expected();
        pulse_start();
        @(negedge clk);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'd1);
        n = 0;
        while (cfg_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 32'(cfg_busy), 32'd0);
        repeat (40) @(negedge clk);
        chk({tag, "_nreq"}, 32'(req_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            chk($sformatf("%s_req%0d", tag, i),
                (i < req_log.size()) ? 32'(req_log[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        chk({tag, "_done"},  32'(cfg_done),  32'(exp_done));
        chk({tag, "_error"}, 32'(cfg_error), 32'(exp_err));
        chk({tag, "_eidx"},  32'(err_index), 32'(exp_idx));
        chk({tag, "_req_idle"}, 32'(i2c_req), 32'd0);
    endtask

    task automatic load_default_table();
        tbl[0] = 24'h3103_11;
        tbl[1] = 24'h3008_82;
        tbl[2] = 24'h3017_FF;
        tbl[3] = 24'h3018_FF;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap5, gap0, diff, n;
        camera_rst = 1'b1;
        cfg_start  = 1'b0;
        m_lat      = 10;
        nack_addr  = 16'h0000;
        nack_lim   = 0;
        corr_addr  = 16'h0000;
        corr_lim   = 0;
        load_default_table();

        repeat (3) @(negedge clk);
        chk("rst_req",   32'(i2c_req),      32'd0);
        chk("rst_busy",  32'(cfg_busy),     32'd0);
        chk("rst_done",  32'(cfg_done),     32'd0);
        chk("rst_error", 32'(cfg_error),    32'd0);
        chk("rst_rom",   32'(rom_addr),     32'd0);
        chk("dev_addr",  32'(i2c_dev_addr), 32'h3C);
        chk("addr16",    32'(i2c_addr16),   32'd1);
        @(posedge clk); #1 camera_rst = 1'b0;

        run_check("basic", 5000);

        tbl[1] = 24'hFFFF_05;
        run_check("dly5", 20000);
        gap5 = (req_cyc.size() > 1 && done_cyc.size() > 0) ? req_cyc[1] - done_cyc[0] : -1;
        tbl[1] = 24'hFFFF_00;
        run_check("dly0", 5000);
        gap0 = (req_cyc.size() > 1 && done_cyc.size() > 0) ? req_cyc[1] - done_cyc[0] : -1;
        chk("dly0_no_wait", 32'((gap0 > 0 && gap0 < 20) ? 1 : 0), 32'd1);
        diff = gap5 - gap0;
        chk("dly5_extra_cycles", 32'((diff >= 4998 && diff <= 5002) ? 5000 : diff), 32'd5000);
        load_default_table();

        nack_addr = 16'h3017;
        nack_lim  = 2;
        run_check("nack2", 5000);
        nack_lim  = 1000;
        run_check("nack_all", 5000);
        nack_lim  = 0;
        run_check("restart", 5000);

        // Asynchronous reset while entry 1 is waiting on the master
        pulse_start();
        n = 0;
        while (req_log.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", 32'(req_log.size()), 32'd2);
        #2 camera_rst = 1'b1;
        #1;
        chk("rst_mid_req",   32'(i2c_req),      32'd0);
        chk("rst_mid_busy",  32'(cfg_busy),     32'd0);
        chk("rst_mid_rom",   32'(rom_addr),     32'd0);
        chk("rst_mid_raddr", 32'(i2c_reg_addr), 32'd0);
        chk("rst_mid_wdata", 32'(i2c_wdata),    32'd0);
        chk("rst_mid_rw",    32'(i2c_rw),       32'd0);
        chk("rst_mid_stat",  32'({cfg_done, cfg_error, err_index}), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 camera_rst = 1'b0;
        run_check("after_rst", 5000);

`ifdef CAM_REG_READBACK_VERIFY_EN
        corr_addr = 16'h3008;
        corr_lim  = 1;
        run_check("verify_retry", 5000);
        corr_lim  = 1000;
        run_check("verify_fail", 5000);
        corr_lim  = 0;
`endif

        m_lat = 0;
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < int'(NE); e++) begin
                if ($urandom_range(0, 3) == 0)
                    tbl[e] = {16'hFFFF, 8'($urandom_range(0, 1))};
                else
                    tbl[e] = {4'h3, 2'(e), 10'($urandom), 8'($urandom)};
            end
            nack_addr = tbl[$urandom_range(0, NE - 1)][23:8];
            nack_lim  = int'($urandom_range(0, 5));
            corr_addr = tbl[$urandom_range(0, NE - 1)][23:8];
            corr_lim  = int'($urandom_range(0, 5));
            run_check($sformatf("rand%0d", r), 20000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
